vga_capture: RTL and testbench
==============================

# vga_capture

Frame-capture receiver for the VGA pixel stream produced by the display pipeline (hsync, vsync, ptick, von, rgb). It locks onto the vsync pulse and rebuilds pixel coordinates from the video-on window. Each active pixel is written into an external frame buffer through a single write port. At the end of every frame it reports a geometry check and a 16-bit checksum, so rendered output can be verified in-system or on the bench without a monitor.

## Interface
- H_ACTIVE, 640: active pixels per line.
- V_ACTIVE, 480: active lines per frame.
- ADDR_W, 19: frame-buffer address width; must satisfy 2^ADDR_W ≥ H_ACTIVE·V_ACTIVE.
- SYNC_LOW, 1: 1 = hsync/vsync asserted low; 0 = asserted high.

Ports:
- clk  in  1  system clock; same clock that drives the VGA generator.
- reset  in  1  asynchronous, active-low reset.
- hsync  in  1  horizontal sync, polarity per SYNC_LOW.
- vsync  in  1  vertical sync, polarity per SYNC_LOW.
- ptick  in  1  pixel-enable strobe, one clk wide.
- von  in  1  video-on; qualifies rgb when ptick=1.
- rgb  in  8  pixel colour.
- wr_en  out  1  frame-buffer write strobe.
- wr_addr  out  ADDR_W  write address = y·H_ACTIVE + x.
- wr_data  out  8  pixel value to write.
- frame_done  out  1  one-cycle pulse at end of frame.
- frame_ok  out  1  latched at frame_done: geometry matched exactly.
- frame_sum  out  16  latched at frame_done: modulo-2^16 sum of written pixels.
- lines_seen  out  10  latched at frame_done: hsync assertions counted in the frame.

## Operation
- All inputs are registered once (stage S1) before any use. Sync edges are detected on S1 against its previous value.
- FSM states:
  - WAIT_VS: entered from reset. Ignores everything until vsync asserts, then goes to IN_VS. No frame_done is issued for this first vsync.
  - IN_VS: waits for vsync to deassert, then clears x, y, sum, hcount and the error flag, and goes to CAPTURE.
  - CAPTURE:
    - On ptick=1 with von=1: if x<H_ACTIVE and y<V_ACTIVE, issue a write of (y·H_ACTIVE+x, rgb) and add rgb to sum; otherwise set err and suppress the write. In both cases x increments (saturating at 2^11−1).
    - On ptick=1, von=0, with the previous qualified pixel having von=1 (end of line): set err if x≠H_ACTIVE; then x←0 and y increments (saturating).
    - On each hsync assertion edge: hcount increments.
    - On vsync assertion edge: latch frame_ok = (!err && y==V_ACTIVE), frame_sum = sum, lines_seen = hcount. Pulse frame_done, then go to IN_VS.
- If a line is still open when vsync asserts (von high at the last pixel), it counts as ended: the x check applies and y increments before frame_ok is evaluated.
- ptick=1 with von=1 while in WAIT_VS or IN_VS: ignored, no write.
- wr_addr is computed as y·H_ACTIVE+x with full-width intermediates, then truncated to ADDR_W.
- Reset mid-frame: the FSM returns to WAIT_VS. The partial frame is discarded and no frame_done is produced.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, frame_done=0, frame_ok=0, frame_sum=0, lines_seen=0. FSM=WAIT_VS, all counters 0.
- Write latency: if rgb is sampled with ptick=1 and von=1 at clk edge k, wr_en/wr_addr/wr_data are high and valid for exactly the single cycle following edge k+2. wr_en is never high two consecutive cycles unless ptick is.
- frame_done: high for one cycle following edge k+2, where edge k samples the vsync assertion. frame_ok, frame_sum and lines_seen update on that same edge and hold until the next frame_done or reset.
- Simultaneous events: if the vsync assertion edge is sampled on the same cycle as a qualified pixel, the pixel is processed first. Its write and sum contribution are included in the frame being closed.
- Throughput: one pixel per clk. ptick may be held high continuously.

## Test plan
All scenarios use H_ACTIVE=4, V_ACTIVE=3, SYNC_LOW=1.
- Nominal frame: vsync pulse, then 3 lines of 4 pixels with rgb = 1..12, each line preceded by an hsync pulse, then vsync. Required: 12 writes to addr 0..11 with data 1..12; frame_done once; frame_ok=1; frame_sum=78; lines_seen=3.
- Short line: line 1 carries only 3 pixels. Required: 11 writes; frame_ok=0; frame_sum = 78 minus the dropped pixel value.
- Long line: line 0 carries 5 pixels. Required: the 5th pixel is not written; addresses stay in 0..11; frame_ok=0.
- Startup: stream enters mid-frame after reset with von active. Required: no writes before the first vsync and no frame_done for the partial frame. The first full frame then reports frame_ok=1.
- Reset mid-frame: pull reset low after 6 pixels. Required: all outputs return to 0 asynchronously; no frame_done until one complete frame has been received.
- Latency and wrap: ptick held high continuously, with rgb=8'hFF for all 12 pixels. Required: wr_en at exactly sample edge+2 for every pixel; frame_sum=16'h0BF4.

Source files
------------

// File: rtl/vga_capture.sv
// VGA frame-capture receiver: rebuilds pixel coordinates from the video-on window,
// writes active pixels to a frame buffer and reports per-frame geometry and checksum.
module vga_capture #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned ADDR_W   = 19,
    parameter bit          SYNC_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hsync,
    input  logic              vsync,
    input  logic              ptick,
    input  logic              von,
    input  logic [7:0]        rgb,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              frame_done,
    output logic              frame_ok,
    output logic [15:0]       frame_sum,
    output logic [9:0]        lines_seen
);

    localparam int unsigned CNT_W  = 11;
    localparam int unsigned HCNT_W = 10;
    localparam int unsigned SUM_W  = 16;
    localparam int unsigned PROD_W = 2 * CNT_W + 1;

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [HCNT_W-1:0] HCNT_MAX = '1;
    localparam logic [CNT_W-1:0]  H_LIM    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0]  V_LIM    = CNT_W'(V_ACTIVE);
    localparam logic [PROD_W-1:0] H_MUL    = PROD_W'(H_ACTIVE);

    typedef enum logic [1:0] {
        WAIT_VS,
        IN_VS,
        CAPTURE
    } state_t;

    // input register stage; syncs normalised to active-high here
    logic       s1_hs, s1_vs, s1_hs_d, s1_vs_d, s1_pt, s1_von;
    logic [7:0] s1_rgb;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_hs   <= 1'b0;
            s1_vs   <= 1'b0;
            s1_hs_d <= 1'b0;
            s1_vs_d <= 1'b0;
            s1_pt   <= 1'b0;
            s1_von  <= 1'b0;
            s1_rgb  <= '0;
        end else begin
            s1_hs   <= hsync ^ SYNC_LOW;
            s1_vs   <= vsync ^ SYNC_LOW;
            s1_hs_d <= s1_hs;
            s1_vs_d <= s1_vs;
            s1_pt   <= ptick;
            s1_von  <= von;
            s1_rgb  <= rgb;
        end
    end

    logic hs_edge, vs_edge;
    assign hs_edge = s1_hs & ~s1_hs_d;
    assign vs_edge = s1_vs & ~s1_vs_d;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    x, x_nxt, y, y_nxt;
    logic [SUM_W-1:0]    sum, sum_nxt;
    logic [HCNT_W-1:0]   hcnt, hcnt_nxt;
    logic                err, err_nxt, last_von, last_von_nxt;
    logic                wr_c, done_c, ok_c;
    logic [PROD_W-1:0]   addr_full;

    assign addr_full = PROD_W'(y) * H_MUL + PROD_W'(x);

    // state and frame counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= WAIT_VS;
            x        <= '0;
            y        <= '0;
            sum      <= '0;
            hcnt     <= '0;
            err      <= 1'b0;
            last_von <= 1'b0;
        end else begin
            state    <= state_nxt;
            x        <= x_nxt;
            y        <= y_nxt;
            sum      <= sum_nxt;
            hcnt     <= hcnt_nxt;
            err      <= err_nxt;
            last_von <= last_von_nxt;
        end
    end

    // next-state, coordinate tracking and frame close
    always_comb begin
        state_nxt    = state;
        x_nxt        = x;
        y_nxt        = y;
        sum_nxt      = sum;
        hcnt_nxt     = hcnt;
        err_nxt      = err;
        last_von_nxt = last_von;
        wr_c         = 1'b0;
        done_c       = 1'b0;
        ok_c         = 1'b0;

        case (state)
            WAIT_VS: begin
                if (s1_vs) state_nxt = IN_VS;
            end
            IN_VS: begin
                if (!s1_vs) begin
                    state_nxt    = CAPTURE;
                    x_nxt        = '0;
                    y_nxt        = '0;
                    sum_nxt      = '0;
                    hcnt_nxt     = '0;
                    err_nxt      = 1'b0;
                    last_von_nxt = 1'b0;
                end
            end
            CAPTURE: begin
                if (s1_pt) begin
                    last_von_nxt = s1_von;
                    if (s1_von) begin
                        if (x < H_LIM && y < V_LIM) begin
                            wr_c    = 1'b1;
                            sum_nxt = sum + SUM_W'(s1_rgb);
                        end else begin
                            err_nxt = 1'b1;
                        end
                        if (x != CNT_MAX) x_nxt = x + CNT_W'(1);
                    end else if (last_von) begin
                        if (x != H_LIM) err_nxt = 1'b1;
                        x_nxt = '0;
                        if (y != CNT_MAX) y_nxt = y + CNT_W'(1);
                    end
                end

                if (hs_edge && hcnt != HCNT_MAX) hcnt_nxt = hcnt + HCNT_W'(1);

                // a pixel on the same cycle is already folded in above
                if (vs_edge) begin
                    if (last_von_nxt) begin
                        if (x_nxt != H_LIM) err_nxt = 1'b1;
                        x_nxt = '0;
                        if (y_nxt != CNT_MAX) y_nxt = y_nxt + CNT_W'(1);
                        last_von_nxt = 1'b0;
                    end
                    done_c    = 1'b1;
                    ok_c      = !err_nxt && (y_nxt == V_LIM);
                    state_nxt = IN_VS;
                end
            end
            default: state_nxt = WAIT_VS;
        endcase
    end

    // pending stage between the counters and the output registers
    logic              wr_p, done_p, ok_p;
    logic [ADDR_W-1:0] addr_p;
    logic [7:0]        data_p;
    logic [SUM_W-1:0]  sum_p;
    logic [HCNT_W-1:0] lines_p;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_p    <= 1'b0;
            addr_p  <= '0;
            data_p  <= '0;
            done_p  <= 1'b0;
            ok_p    <= 1'b0;
            sum_p   <= '0;
            lines_p <= '0;
        end else begin
            wr_p   <= wr_c;
            done_p <= done_c;
            if (wr_c) begin
                addr_p <= ADDR_W'(addr_full);
                data_p <= s1_rgb;
            end
            if (done_c) begin
                ok_p    <= ok_c;
                sum_p   <= sum_nxt;
                lines_p <= hcnt_nxt;
            end
        end
    end

    // output registers; frame results hold until the next frame close
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            frame_sum  <= '0;
            lines_seen <= '0;
        end else begin
            wr_en      <= wr_p;
            wr_addr    <= addr_p;
            wr_data    <= data_p;
            frame_done <= done_p;
            if (done_p) begin
                frame_ok   <= ok_p;
                frame_sum  <= sum_p;
                lines_seen <= lines_p;
            end
        end
    end

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture on a 4x3 frame: geometry, checksum, latency and reset behaviour.
module tb_vga_capture;

    localparam int unsigned H  = 4;
    localparam int unsigned V  = 3;
    localparam int unsigned AW = 4;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic          hsync = 1'b1;
    logic          vsync = 1'b1;
    logic          ptick = 1'b0;
    logic          von   = 1'b0;
    logic [7:0]    rgb   = 8'h00;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          frame_done;
    logic          frame_ok;
    logic [15:0]   frame_sum;
    logic [9:0]    lines_seen;

    vga_capture #(
        .H_ACTIVE(H),
        .V_ACTIVE(V),
        .ADDR_W  (AW),
        .SYNC_LOW(1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .hsync     (hsync),
        .vsync     (vsync),
        .ptick     (ptick),
        .von       (von),
        .rgb       (rgb),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .frame_done(frame_done),
        .frame_ok  (frame_ok),
        .frame_sum (frame_sum),
        .lines_seen(lines_seen)
    );

    always #5 clk = ~clk;

    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   d0 = 0;
    int   wr_a_q[$], wr_d_q[$], wr_c_q[$];
    int   ex_a_q[$], ex_d_q[$], ex_c_q[$];
    bit   model_on = 1'b0;
    logic idle_pt = 1'b0;
    int   pgap = 1;

    always @(posedge clk) cyc <= cyc + 1;

    // write/frame_done monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (wr_en) begin
            wr_a_q.push_back(int'(wr_addr));
            wr_d_q.push_back(int'(wr_data));
            wr_c_q.push_back(cyc);
        end
        if (frame_done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        else n_pass++;
    endtask

    task automatic step(input logic hs_a, input logic vs_a, input logic pt, input logic v,
                        input logic [7:0] c);
        @(negedge clk);
        hsync = !hs_a;
        vsync = !vs_a;
        ptick = pt;
        von   = v;
        rgb   = c;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, idle_pt, 1'b0, 8'h00);
    endtask

    task automatic vs_pulse();
        repeat (3) step(1'b0, 1'b1, idle_pt, 1'b0, 8'h00);
        idle(2);
    endtask

    task automatic hs_pulse();
        repeat (2) step(1'b1, 1'b0, idle_pt, 1'b0, 8'h00);
    endtask

    // one ptick; a written pixel must appear 3 falling edges after the drive edge
    task automatic pix(input logic v, input logic [7:0] c, input bit exp_wr, input int a);
        step(1'b0, 1'b0, 1'b1, v, c);
        if (exp_wr) begin
            ex_a_q.push_back(a);
            ex_d_q.push_back(int'(c));
            ex_c_q.push_back(cyc + 3);
        end
        repeat (pgap) step(1'b0, 1'b0, 1'b0, v, c);
    endtask

    task automatic send_line(input int ln, input int n, input int first, input int inc);
        hs_pulse();
        idle(2);
        for (int i = 0; i < n; i++)
            pix(1'b1, 8'(first + i * inc), model_on && (i < int'(H)), ln * int'(H) + i);
        pix(1'b0, 8'h00, 1'b0, 0);
        idle(1);
    endtask

    task automatic begin_frame();
        wr_a_q.delete(); wr_d_q.delete(); wr_c_q.delete();
        ex_a_q.delete(); ex_d_q.delete(); ex_c_q.delete();
        d0 = done_cnt;
    endtask

    task automatic end_frame(input string tag, input int ok, input int sum, input int lines);
        int n;
        check({tag, "_done"}, 32'(done_cnt - d0), 1);
        check({tag, "_ok"}, 32'(frame_ok), 32'(ok));
        check({tag, "_sum"}, 32'(frame_sum), 32'(sum));
        check({tag, "_lines"}, 32'(lines_seen), 32'(lines));
        check({tag, "_nwr"}, 32'(wr_a_q.size()), 32'(ex_a_q.size()));
        n = (wr_a_q.size() < ex_a_q.size()) ? wr_a_q.size() : ex_a_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_addr%0d", tag, i), 32'(wr_a_q[i]), 32'(ex_a_q[i]));
            check($sformatf("%s_data%0d", tag, i), 32'(wr_d_q[i]), 32'(ex_d_q[i]));
            check($sformatf("%s_cyc%0d", tag, i), 32'(wr_c_q[i]), 32'(ex_c_q[i]));
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_wr_en"}, 32'(wr_en), 0);
        check({tag, "_wr_addr"}, 32'(wr_addr), 0);
        check({tag, "_wr_data"}, 32'(wr_data), 0);
        check({tag, "_done"}, 32'(frame_done), 0);
        check({tag, "_ok"}, 32'(frame_ok), 0);
        check({tag, "_sum"}, 32'(frame_sum), 0);
        check({tag, "_lines"}, 32'(lines_seen), 0);
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check_zero("rst");
        reset = 1'b1;

        // startup mid-frame with von active: ignored until first vsync, no frame_done
        begin_frame();
        model_on = 1'b0;
        send_line(1, 4, 50, 1);
        send_line(2, 4, 60, 1);
        vs_pulse();
        idle(2);
        check("start_nwr", 32'(wr_a_q.size()), 0);
        check("start_done", 32'(done_cnt - d0), 0);

        // nominal frame
        begin_frame();
        model_on = 1'b1;
        send_line(0, 4, 1, 1);
        send_line(1, 4, 5, 1);
        send_line(2, 4, 9, 1);
        vs_pulse();
        idle(4);
        end_frame("nom", 1, 78, 3);

        // short line: pixel 8 missing
        begin_frame();
        send_line(0, 4, 1, 1);
        send_line(1, 3, 5, 1);
        send_line(2, 4, 9, 1);
        vs_pulse();
        idle(4);
        end_frame("short", 0, 70, 3);

        // long line: fifth pixel of line 0 dropped
        begin_frame();
        send_line(0, 5, 1, 1);
        send_line(1, 4, 6, 1);
        send_line(2, 4, 10, 1);
        vs_pulse();
        idle(4);
        end_frame("long", 0, 86, 3);

        // reset after 6 pixels, asserted between clock edges
        begin_frame();
        model_on = 1'b0;
        send_line(0, 4, 1, 1);
        hs_pulse();
        idle(2);
        pix(1'b1, 8'd5, 1'b0, 0);
        pix(1'b1, 8'd6, 1'b0, 0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check_zero("mid");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        begin_frame();
        pix(1'b1, 8'd7, 1'b0, 0);
        pix(1'b1, 8'd8, 1'b0, 0);
        pix(1'b0, 8'd0, 1'b0, 0);
        send_line(2, 4, 9, 1);
        vs_pulse();
        idle(2);
        check("mid_nwr", 32'(wr_a_q.size()), 0);
        check("mid_done", 32'(done_cnt - d0), 0);

        // continuous ptick, all pixels 0xFF: checksum 12*255 = 0x0BF4
        begin_frame();
        model_on = 1'b1;
        pgap     = 0;
        idle_pt  = 1'b1;
        send_line(0, 4, 255, 0);
        send_line(1, 4, 255, 0);
        send_line(2, 4, 255, 0);
        vs_pulse();
        idle(4);
        end_frame("lat", 1, 16'h0BF4, 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
